// File: rtl/aes_main.sv
// Iterative AES-128/192/256: key expansion, encrypt, then decrypt of the produced ciphertext.
// Define AES_DECRYPT_EN to include the DEC phase; otherwise out2 is tied to zero.
module aes_main (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data,
  input  logic [1:0]   bits,
  input  logic [127:0] key1,
  input  logic [191:0] key2,
  input  logic [255:0] key3,
  output logic [127:0] out1,
  output logic [127:0] out2,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, KEY, ENC, DONE
`ifdef AES_DECRYPT_EN
    , DEC
`endif
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic fin);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = t[127-32*c -: 32];
        t[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return t ^ rk;
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic fin);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
    t = t ^ rk;
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = t[127-32*c -: 32];
        t[127-32*c -: 32] = {
          gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
          gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
          gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
          gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
      end
    end
    return t;
  endfunction
`endif

  function automatic logic [3:0] nk_of(input logic [1:0] sz);
    case (sz)
      2'd1:    return 4'd6;
      2'd2:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    ksz_q, ksz_d;
  logic [127:0]  data_q, data_d;
  logic [127:0]  st_q, st_d;
  logic [5:0]    idx_q, idx_d;
  logic [2:0]    kmod_q, kmod_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          first_q, first_d;
  logic [127:0]  out1_q, out1_d;
  logic          done_q, done_d;
  logic [31:0]   w_q [60];
  logic [31:0]   w_d [60];

  logic [3:0]    nk, nr;
  logic [5:0]    last_idx;
  logic [255:0]  key_sel;
  logic [127:0]  rk;
  logic [31:0]   kw;
  logic [127:0]  enc_res;

  assign nk       = nk_of(ksz_q);
  assign nr       = nk + 4'd6;
  assign last_idx = {nr + 4'd1, 2'b00} - 6'd1;
  assign key_sel  = (bits == 2'd1) ? {key2, 64'h0} : (bits == 2'd2) ? key3 : {key1, 128'h0};
  assign rk       = {w_q[{rnd_q, 2'd0}], w_q[{rnd_q, 2'd1}], w_q[{rnd_q, 2'd2}], w_q[{rnd_q, 2'd3}]};

`ifdef AES_DECRYPT_EN
  logic [127:0]  out2_q, out2_d;
  logic [127:0]  dec_res;
  assign out2 = out2_q;
`else
  assign out2 = '0;
`endif
  assign out1 = out1_q;
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    ksz_d   = ksz_q;
    data_d  = data_q;
    st_d    = st_q;
    idx_d   = idx_q;
    kmod_d  = kmod_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    first_d = first_q;
    out1_d  = out1_q;
    done_d  = 1'b0;
    w_d     = w_q;
    kw      = '0;
    enc_res = '0;
`ifdef AES_DECRYPT_EN
    out2_d  = out2_q;
    dec_res = '0;
`endif
    case (state_q)
      IDLE: if (start) begin
        ksz_d  = (bits == 2'd3) ? 2'd0 : bits;
        data_d = data;
        for (int j = 0; j < 8; j++) w_d[j] = key_sel[255-32*j -: 32];
        idx_d   = {2'b00, nk_of(bits)};
        kmod_d  = 3'd0;
        rcon_d  = 8'h01;
        state_d = KEY;
      end
      KEY: begin
        kw = w_q[idx_q - 6'd1];
        if (kmod_q == 3'd0) begin
          kw     = sub_word({kw[23:0], kw[31:24]}) ^ {rcon_q, 24'h0};
          rcon_d = xtime(rcon_q);
        end else if (ksz_q == 2'd2 && kmod_q == 3'd4) begin
          kw = sub_word(kw);
        end
        w_d[idx_q] = w_q[idx_q - {2'b00, nk}] ^ kw;
        kmod_d = ({1'b0, kmod_q} == nk - 4'd1) ? 3'd0 : kmod_q + 3'd1;
        idx_d  = idx_q + 6'd1;
        if (idx_q == last_idx) begin
          state_d = ENC;
          rnd_d   = 4'd0;
          first_d = 1'b1;
        end
      end
      ENC: begin
        if (first_q) begin
          st_d    = data_q ^ rk;
          rnd_d   = 4'd1;
          first_d = 1'b0;
        end else begin
          enc_res = enc_round(st_q, rk, rnd_q == nr);
          st_d    = enc_res;
          if (rnd_q == nr) begin
            out1_d = enc_res;
`ifdef AES_DECRYPT_EN
            state_d = DEC;
            first_d = 1'b1;
`else
            state_d = DONE;
`endif
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
`ifdef AES_DECRYPT_EN
      // rnd_q enters at Nr from ENC and counts down to round key 0
      DEC: begin
        if (first_q) begin
          st_d    = out1_q ^ rk;
          rnd_d   = rnd_q - 4'd1;
          first_d = 1'b0;
        end else begin
          dec_res = dec_round(st_q, rk, rnd_q == 4'd0);
          st_d    = dec_res;
          if (rnd_q == 4'd0) begin
            out2_d  = dec_res;
            state_d = DONE;
          end else begin
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ksz_q   <= 2'd0;
      data_q  <= '0;
      st_q    <= '0;
      idx_q   <= '0;
      kmod_q  <= '0;
      rcon_q  <= 8'h01;
      rnd_q   <= '0;
      first_q <= 1'b0;
      out1_q  <= '0;
      done_q  <= 1'b0;
`ifdef AES_DECRYPT_EN
      out2_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ksz_q   <= ksz_d;
      data_q  <= data_d;
      st_q    <= st_d;
      idx_q   <= idx_d;
      kmod_q  <= kmod_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      first_q <= first_d;
      out1_q  <= out1_d;
      done_q  <= done_d;
`ifdef AES_DECRYPT_EN
      out2_q  <= out2_d;
`endif
    end
  end

  // round-key store carries no reset; it is always rewritten before use
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

endmodule

// File: tb/tb_aes_main.sv
// Scoreboard bench for aes_main: FIPS-197 vectors, reset abort, held start, random requests.
module tb_aes_main;
  logic         clk = 1'b0;
  logic         reset, start, done;
  logic [1:0]   bits;
  logic [127:0] data, key1, out1, out2;
  logic [191:0] key2;
  logic [255:0] key3;

  aes_main dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .bits(bits),
    .key1(key1), .key2(key2), .key3(key3), .out1(out1), .out2(out2), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] o1;
    logic [127:0] o2;
    int           at;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         me;
  int           n_chk = 0;
  int           n_fail = 0;
  logic [7:0]   sb [256];

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K2     = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K3     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Multiplicative-generator walk: p steps by x3, q by its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model_enc(input logic [1:0] sz, input logic [255:0] k,
                                             input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   rcon [11];
    logic [31:0]  t;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    int           nk, nr;
    rcon = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nk = (sz == 2'd1) ? 6 : (sz == 2'd2) ? 8 : 4;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0)
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon[i/nk], 24'h0};
      else if (nk == 8 && i % nk == 4)
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      w[i] = w[i-nk] ^ t;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) u[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = u[4*((c+rw)%4)+rw];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
          s[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [255:0] key_for(input logic [1:0] sz);
    case (sz)
      2'd1:    return {key2, 64'h0};
      2'd2:    return key3;
      default: return {key1, 128'h0};
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] sz);
`ifdef AES_DECRYPT_EN
    case (sz) 2'd1: return 73; 2'd2: return 83; default: return 63; endcase
`else
    case (sz) 2'd1: return 60; 2'd2: return 68; default: return 52; endcase
`endif
  endfunction

  function automatic logic [127:0] out2_of(input logic [127:0] pt);
`ifdef AES_DECRYPT_EN
    return pt;
`else
    return 128'h0 & pt;
`endif
  endfunction

  task automatic push_exp(input logic [127:0] ct, input logic [127:0] pt, input int at);
    exp_t e;
    e.o1 = ct;
    e.o2 = out2_of(pt);
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] sz, input logic [127:0] pt, input logic [127:0] ct);
    bits  = sz;
    data  = pt;
    start = 1'b1;
    push_exp(ct, pt, cyc + 1 + lat_of(sz));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
        end else begin
          me = exp_q.pop_front();
          chk("out1", out1, me.o1);
          chk("out2", out2, me.o2);
          chk("latency", 128'(cyc), 128'(me.at));
        end
      end
    end
  end

  initial begin
    logic [127:0] pt2;
    logic [1:0]   sz;
    int           at1, i;
    build_sbox();
    reset = 1'b1; start = 1'b0; bits = 2'd0; data = '0;
    key1 = '0; key2 = '0; key3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out1", out1, 128'h0);
    chk("reset_out2", out2, 128'h0);
    chk("reset_done", 128'(done), 128'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    key1 = K1; key2 = K2; key3 = K3;
    issue(2'd0, PT, CT128); wait_idle();
    issue(2'd1, PT, CT192); wait_idle();
    issue(2'd2, PT, CT256); wait_idle();

    // abort a 256-bit run while the key schedule is still expanding
    bits = 2'd2; data = PT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_out1", out1, 128'h0);
    chk("abort_out2", out2, 128'h0);
    chk("abort_done", 128'(done), 128'h0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    issue(2'd0, PT, CT128); wait_idle();

    // start held high; inputs change mid-run, second request begins right after done
    pt2   = {$urandom, $urandom, $urandom, $urandom};
    bits  = 2'd0; data = PT; start = 1'b1;
    at1   = cyc + 1 + lat_of(2'd0);
    push_exp(CT128, PT, at1);
    @(posedge clk); #1;
    bits  = 2'd2; data = pt2;
    push_exp(model_enc(2'd2, key3, pt2), pt2, at1 + 1 + lat_of(2'd2));
    i = 0;
    while (done !== 1'b1 && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (done !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL held_start_timeout: done=%b, required 1", done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    issue(2'd3, PT, CT128); wait_idle();

    for (int k = 0; k < 12; k++) begin
      key1 = {$urandom, $urandom, $urandom, $urandom};
      key2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      key3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sz   = 2'($urandom_range(0, 3));
      pt2  = {$urandom, $urandom, $urandom, $urandom};
      issue(sz, pt2, model_enc(sz, key_for(sz), pt2));
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
